// File: rtl/morse_timed_decoder.sv
// Straight-key Morse front end: times key marks and gaps against a unit
// length, assembles dot/dash elements into letters and queues letters and
// word spaces in a small FIFO for the downstream decoder.
module morse_timed_decoder #(
  parameter int UNIT_TICKS = 100,
  parameter int MAX_LEN    = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              key,
  output logic [MAX_LEN-1:0]                out_code,
  output logic [$clog2(MAX_LEN+1)-1:0]      out_len,
  output logic                              out_space,
  output logic                              out_toolong,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int TW = $clog2(7 * UNIT_TICKS + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = MAX_LEN + LW + 2;

  localparam logic [TW-1:0] DASH_T   = TW'(2 * UNIT_TICKS);
  localparam logic [TW-1:0] LETTER_T = TW'(3 * UNIT_TICKS);
  localparam logic [TW-1:0] WORD_T   = TW'(7 * UNIT_TICKS);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;

  logic               key_q_r;
  logic [1:0]         state_r;
  logic [TW-1:0]      timer_r;
  logic [MAX_LEN-1:0] code_r;
  logic [LW-1:0]      len_r;
  logic               toolong_r;
  logic               letter_open_r;

  logic               rise_s;
  logic               fall_s;
  logic [TW-1:0]      timer_inc_s;
  logic               letter_hit_s;
  logic               word_hit_s;
  logic               push_s;
  logic [EW-1:0]      push_data_s;

  logic [EW-1:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               overflow_r;
  logic               pop_s;
  logic               accept_s;

  assign rise_s = key & ~key_q_r;
  assign fall_s = ~key & key_q_r;

  // Key history; starts high so a key held through reset must be released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q_r <= 1'b1;
    end else begin
      key_q_r <= key;
    end
  end

  // Saturating timer value including this cycle's tick.
  always_comb begin
    timer_inc_s = timer_r;
    if (tick && (timer_r != {TW{1'b1}})) begin
      timer_inc_s = timer_r + TW'(1);
    end else begin
      timer_inc_s = timer_r;
    end
  end

  // Gap thresholds; a new mark at the word boundary cancels the word space.
  always_comb begin
    letter_hit_s = 1'b0;
    word_hit_s   = 1'b0;
    push_s       = 1'b0;
    push_data_s  = {EW{1'b0}};
    if ((state_r == ST_SPACE) && tick) begin
      letter_hit_s = letter_open_r && (timer_inc_s == LETTER_T);
      word_hit_s   = !rise_s && (timer_inc_s == WORD_T);
    end else begin
      letter_hit_s = 1'b0;
      word_hit_s   = 1'b0;
    end
    if (letter_hit_s) begin
      push_s      = 1'b1;
      push_data_s = {1'b0, toolong_r, len_r, code_r};
    end else if (word_hit_s) begin
      push_s      = 1'b1;
      push_data_s = {1'b1, 1'b0, {LW{1'b0}}, {MAX_LEN{1'b0}}};
    end else begin
      push_s      = 1'b0;
      push_data_s = {EW{1'b0}};
    end
  end

  // Mark/gap state machine and letter assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TW{1'b0}};
      code_r        <= {MAX_LEN{1'b0}};
      len_r         <= {LW{1'b0}};
      toolong_r     <= 1'b0;
      letter_open_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_MARK;
            timer_r <= {TW{1'b0}};
          end
        end
        ST_MARK: begin
          if (fall_s) begin
            if (len_r == LEN_MAX) begin
              toolong_r <= 1'b1;
            end else begin
              code_r <= {code_r[MAX_LEN-2:0], (timer_inc_s >= DASH_T)};
              len_r  <= len_r + LW'(1);
            end
            state_r       <= ST_SPACE;
            timer_r       <= {TW{1'b0}};
            letter_open_r <= 1'b1;
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        ST_SPACE: begin
          if (letter_hit_s) begin
            code_r        <= {MAX_LEN{1'b0}};
            len_r         <= {LW{1'b0}};
            toolong_r     <= 1'b0;
            letter_open_r <= 1'b0;
          end
          if (rise_s) begin
            state_r <= ST_MARK;
            timer_r <= {TW{1'b0}};
          end else if (word_hit_s) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign pop_s    = (count_r != {CW{1'b0}}) && out_ready;
  assign accept_s = push_s && ((count_r != FULL_C) || pop_s);

  // FIFO storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, occupancy and dropped-push flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      overflow_r <= push_s && !accept_s;
    end
  end

  assign {out_space, out_toolong, out_len, out_code} = mem_r[rd_ptr_r];
  assign out_valid  = (count_r != {CW{1'b0}});
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_morse_timed_decoder.sv
// Directed bench for morse_timed_decoder with UNIT_TICKS=4 and tick held high.
module tb_morse_timed_decoder;

  localparam int UT = 4;
  localparam int ML = 6;
  localparam int FD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key;
  logic [5:0] out_code;
  logic [2:0] out_len;
  logic       out_space;
  logic       out_toolong;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [3:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int fall_cyc = 0;
  logic [10:0] popq[$];
  int          popc[$];

  localparam logic [10:0] DOT_LETTER = {1'b0, 1'b0, 3'd1, 6'b000000};
  localparam logic [10:0] SPACE_ENT  = {1'b1, 1'b0, 3'd0, 6'b000000};

  morse_timed_decoder #(.UNIT_TICKS(UT), .MAX_LEN(ML), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key),
    .out_code(out_code), .out_len(out_len), .out_space(out_space),
    .out_toolong(out_toolong), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp popped entries.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every entry the consumer takes and count overflow pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        popq.push_back({out_space, out_toolong, out_len, out_code});
        popc.push_back(cyc);
      end
      if (overflow) ovf_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] q_at(input int i);
    if (i < popq.size()) return popq[i];
    return 11'h7ff;
  endfunction

  function automatic int c_at(input int i);
    if (i < popc.size()) return popc[i];
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    cycles(n);
    key = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic clear_q();
    popq.delete();
    popc.delete();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; key = 1'b0; out_ready = 1'b1;
    cycles(3);
    check_eq("reset_outputs",
             {20'd0, out_space, out_toolong, out_len, out_code},
             32'd0);
    check_eq("reset_ctrl", {28'd0, out_valid, overflow, fifo_count[1:0]}, 32'd0);
    check_eq("reset_count", {28'd0, fifo_count}, 32'd0);
    rst = 1'b0;
    cycles(3);

    // Letter A: dot then dash, then letter and word boundaries.
    clear_q();
    press(4); cycles(4);
    press(12); cycles(40);
    check_eq("a_entries", popq.size(), 32'd2);
    check_eq("a_letter", {21'd0, q_at(0)}, {21'd0, 1'b0, 1'b0, 3'd2, 6'b000001});
    check_eq("a_letter_time", c_at(0), fall_cyc + 12);
    check_eq("a_space", {21'd0, q_at(1)}, {21'd0, SPACE_ENT});
    check_eq("a_space_time", c_at(1), fall_cyc + 28);
    check_eq("a_count_end", {28'd0, fifo_count}, 32'd0);

    // Dot/dash boundary at two units.
    clear_q();
    press(7); cycles(40);
    check_eq("hold7_len", {29'd0, q_at(0)[8:6]}, 32'd1);
    check_eq("hold7_bit0", {31'd0, q_at(0)[0]}, 32'd0);
    clear_q();
    press(8); cycles(40);
    check_eq("hold8_len", {29'd0, q_at(0)[8:6]}, 32'd1);
    check_eq("hold8_bit0", {31'd0, q_at(0)[0]}, 32'd1);

    // Seven dots overflow a six-element letter.
    clear_q();
    repeat (7) begin
      press(4); cycles(4);
    end
    cycles(40);
    check_eq("toolong_entries", popq.size(), 32'd2);
    check_eq("toolong_letter", {21'd0, q_at(0)}, {21'd0, 1'b0, 1'b1, 3'd6, 6'b000000});

    // Nine letters into a stalled FIFO; letter i carries elements i[2:0].
    clear_q();
    out_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      for (int j = 2; j >= 0; j--) begin
        press(((i >> j) & 1) != 0 ? 8 : 4);
        if (j > 0) cycles(4);
      end
      if (i < 8) cycles(16);
    end
    cycles(14);
    check_eq("full_count", {28'd0, fifo_count}, 32'd8);
    check_eq("full_ovf", ovf_cnt, 32'd1);
    check_eq("full_head", {21'd0, out_space, out_toolong, out_len, out_code},
             {21'd0, 1'b0, 1'b0, 3'd3, 6'b000000});
    out_ready = 1'b1;
    cycles(40);
    check_eq("drain_entries", popq.size(), 32'd9);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("drain_%0d", i), {21'd0, q_at(i)},
               {21'd0, 1'b0, 1'b0, 3'd3, 3'b000, 3'(i)});
    end
    check_eq("drain_space", {21'd0, q_at(8)}, {21'd0, SPACE_ENT});
    check_eq("drain_ovf", ovf_cnt, 32'd1);
    check_eq("drain_count", {28'd0, fifo_count}, 32'd0);

    // A 20-tick gap separates letters without a word space.
    clear_q();
    press(4); cycles(20);
    press(4); cycles(40);
    check_eq("gap20_entries", popq.size(), 32'd3);
    check_eq("gap20_l0", {21'd0, q_at(0)}, {21'd0, DOT_LETTER});
    check_eq("gap20_l1", {21'd0, q_at(1)}, {21'd0, DOT_LETTER});
    check_eq("gap20_sp", {21'd0, q_at(2)}, {21'd0, SPACE_ENT});

    // Reset during a mark with a queued entry and the key held.
    out_ready = 1'b0;
    press(4); cycles(14);
    check_eq("pre_rst_count", {28'd0, fifo_count}, 32'd1);
    key = 1'b1;
    cycles(3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_outs",
             {19'd0, out_valid, out_space, out_toolong, out_len, out_code},
             32'd0);
    check_eq("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    cycles(2);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_q();
    cycles(10);
    key = 1'b0;
    cycles(40);
    check_eq("held_key_entries", popq.size(), 32'd0);
    check_eq("held_key_count", {28'd0, fifo_count}, 32'd0);
    press(4); cycles(40);
    check_eq("post_rst_entries", popq.size(), 32'd2);
    check_eq("post_rst_letter", {21'd0, q_at(0)}, {21'd0, DOT_LETTER});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_timed_decoder.md
Name: morse_timed_decoder

Overview:
- Next-generation Morse input stage that decodes a single straight key by timing, replacing the separate dot/dash/confirm buttons.
- Classifies marks as dot or dash and gaps as element, letter or word boundaries, all relative to a parametrised unit time.
- Pushes completed letters and word spaces into an on-chip FIFO with a valid/ready output, feeding the existing morse_decoder / seg7 path.
- Sits after debounce; counts enable pulses from clk_divider.

Parameters:
- UNIT_TICKS, 100, ticks per Morse unit (at 1 kHz tick = 100 ms).
- MAX_LEN, 6, maximum elements per letter; width of out_code.
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick  in  1  single-cycle timing enable; the only event that advances timers
- key  in  1  debounced key level, 1 = pressed
- out_code  out  MAX_LEN  element bits, 1 = dash, bit0 = last element
- out_len  out  $clog2(MAX_LEN+1)  element count, 0 for a space entry
- out_space  out  1  entry is a word space
- out_toolong  out  1  letter exceeded MAX_LEN
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- overflow  out  1  one-cycle pulse when a push is dropped
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; state IDLE; code, len, toolong and timer cleared.
  - key_q (registered key) resets to 1, so a key held through reset is ignored until released.
- Edge detection: rise = key & ~key_q; fall = ~key & key_q.
- Timer width is $clog2(7*UNIT_TICKS+1). It increments only on tick and saturates at its maximum.
- States:
  - IDLE:
    - rise -> MARK, timer = 0.
  - MARK:
    - timer counts ticks while the key is held.
    - fall -> element appended: dash if timer ≥ 2*UNIT_TICKS, else dot.
    - Append: code = {code[MAX_LEN-2:0], bit}, len + 1.
    - If len == MAX_LEN already, the element is discarded and toolong is set.
    - Then -> SPACE, timer = 0, letter_open = 1.
  - SPACE:
    - timer counts ticks.
    - When timer reaches 3*UNIT_TICKS with letter_open: push {space=0, toolong, len, code}, clear code/len/toolong, letter_open = 0.
    - When timer reaches 7*UNIT_TICKS: push {space=1, toolong=0, len=0, code=0} -> IDLE.
    - rise before 3 units -> MARK, same letter continues.
    - rise between 3 and 7 units -> MARK, new letter, no space pushed.
- Push timing: the push occurs in the cycle the threshold is reached (tick cycle). out_valid rises the following cycle.
- fall and the element append: the element is registered one cycle after fall is sampled.
- FIFO:
  - Entry is {space, toolong, len, code}.
  - out_* present the head combinationally from storage; out_valid = count != 0.
  - Pop when out_valid & out_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle. Otherwise the entry is dropped and overflow pulses for one cycle; count stays FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- A word-space push never occurs without a preceding letter: SPACE is entered only from MARK.
- Reset mid-operation: the partial letter and the FIFO are discarded immediately (asynchronous).

Test Plan:
- UNIT_TICKS=4, tick=1 every cycle, out_ready=1. Key "A": hold 4, release 4, hold 12, release, idle 40 -> entry code=…01 len=2 space=0 at 12 cycles of gap; space entry at 28 cycles of gap; fifo_count returns to 0.
- Dash boundary: hold exactly 7 ticks -> len=1, code bit0=0; hold 8 ticks -> bit0=1.
- MAX_LEN=6, seven dots at 4-tick gaps -> single entry len=6, code=000000, toolong=1.
- out_ready=0, FIFO_DEPTH=8, nine letters -> fifo_count=8, overflow pulses once, head is still the first letter. Raise out_ready -> 8 entries drain in order.
- Gap of 20 ticks between letters, then a new mark -> two letter entries, no space entry between them.
- Assert rst during MARK with key held -> outputs 0, FIFO empty. Key stays high after reset -> no element. Release then press 4 ticks -> normal dot decoded.
